// File: rtl/motor_ramp_drive.sv
// motor_ramp_drive: converts a 3-bit motion mode into per-wheel H-bridge pins and ramped PWM.
// Define MOTOR_BRAKE_EN to drive 11 (active brake) instead of 00 (coast) while a wheel is idle or dwelling.
module motor_ramp_drive #(
  parameter int PWM_BITS      = 10,
  parameter int DUTY_RUN      = 800,
  parameter int DUTY_TURN     = 600,
  parameter int RAMP_STEP     = 16,
  parameter int REVERSE_DELAY = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode_i,
  output logic [1:0] pwm_o,
  output logic [1:0] l_in_o,
  output logic [1:0] r_in_o,
  output logic       settled_o
);
  localparam int MAX = 2**PWM_BITS - 1;
  localparam int DW = REVERSE_DELAY < 2 ? 1 : $clog2(REVERSE_DELAY + 1);
  localparam logic [PWM_BITS-1:0] RUN = PWM_BITS'(DUTY_RUN > MAX ? MAX : DUTY_RUN);
  localparam logic [PWM_BITS-1:0] TURN = PWM_BITS'(DUTY_TURN > MAX ? MAX : DUTY_TURN);
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP > MAX ? MAX : RAMP_STEP);
  localparam logic [DW-1:0] DLY = DW'(REVERSE_DELAY);
  localparam logic [1:0] OFF = 2'b00;
  localparam logic [1:0] FWD = 2'b10;
  localparam logic [1:0] BWD = 2'b01;
`ifdef MOTOR_BRAKE_EN
  localparam logic [1:0] IDLE = 2'b11;
`else
  localparam logic [1:0] IDLE = 2'b00;
`endif

  typedef enum logic [1:0] {DRIVE, RAMP_DOWN, DWELL} state_t;
  typedef struct packed {
    state_t              st;
    logic [1:0]          dir;
    logic [PWM_BITS-1:0] duty;
    logic [DW-1:0]       dwell;
  } wheel_t;

  function automatic logic [PWM_BITS-1:0] toward(input logic [PWM_BITS-1:0] d, input logic [PWM_BITS-1:0] t);
    return t > d ? (t - d > STEP ? d + STEP : t) : (d - t > STEP ? d - STEP : t);
  endfunction

  // One boundary's worth of progress for a single wheel.
  function automatic wheel_t step(input wheel_t c, input logic [1:0] req, input logic [PWM_BITS-1:0] tgt);
    wheel_t n;
    logic [PWM_BITS-1:0] dn;
    n = c;
    dn = toward(c.duty, '0);
    case (c.st)
      DRIVE: begin
        if (req == OFF || req == c.dir) begin
          n.duty = toward(c.duty, tgt);
          if (req == OFF && n.duty == '0) n.dir = OFF;
        end else if (c.dir == OFF) begin
          n.dir = req;
          n.duty = toward('0, tgt);
        end else begin
          n.duty = dn;
          n.st = dn == '0 ? DWELL : RAMP_DOWN;
          n.dwell = '0;
        end
      end
      RAMP_DOWN: begin
        n.duty = dn;
        n.st = dn == '0 ? DWELL : RAMP_DOWN;
      end
      DWELL: begin
        n.dwell = c.dwell + DW'(1);
        if (n.dwell >= DLY) begin
          n.st = DRIVE;
          n.dir = req;
          n.duty = toward('0, tgt);
          n.dwell = '0;
        end
      end
      default: n.st = DRIVE;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] pins(input wheel_t w);
    return w.st == DWELL || w.dir == OFF ? IDLE : w.dir;
  endfunction

  wheel_t [1:0] whl_q, whl_d;
  logic [1:0][1:0] req;
  logic [PWM_BITS-1:0] cnt_q, cnt_d, tgt;
  logic [1:0] pwm_q, pwm_d, l_in_q, r_in_q, ok;
  logic settled_q, fwd, bwd, lft, rgt;

  always_comb begin
    fwd = mode_i == 3'b011;
    bwd = mode_i == 3'b100;
    lft = mode_i == 3'b010;
    rgt = mode_i == 3'b001;
    tgt = fwd || bwd ? RUN : lft || rgt ? TURN : '0;
    req[1] = fwd || rgt ? FWD : bwd || lft ? BWD : OFF;
    req[0] = fwd || lft ? FWD : bwd || rgt ? BWD : OFF;
    cnt_d = cnt_q + PWM_BITS'(1);
    for (int i = 0; i < 2; i++) begin
      whl_d[i] = &cnt_q ? step(whl_q[i], req[i], tgt) : whl_q[i];
      pwm_d[i] = cnt_d < whl_d[i].duty;
      ok[i] = whl_q[i].st == DRIVE && whl_q[i].duty == tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      whl_q <= '0;
      pwm_q <= '0;
      l_in_q <= '0;
      r_in_q <= '0;
      settled_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      whl_q <= whl_d;
      pwm_q <= pwm_d;
      l_in_q <= pins(whl_d[1]);
      r_in_q <= pins(whl_d[0]);
      settled_q <= &ok;
    end
  end

  assign pwm_o = pwm_q;
  assign l_in_o = l_in_q;
  assign r_in_o = r_in_q;
  assign settled_o = settled_q;
endmodule

// File: tb/tb_motor_ramp_drive.sv
// tb_motor_ramp_drive: directed table plus randomized modes/resets checked against a period-level model.
module tb_motor_ramp_drive;
  localparam int MAXC = 15, RUN = 12, TURN = 8, STEP = 4, DLY = 2;
`ifdef MOTOR_BRAKE_EN
  localparam logic [1:0] OFF = 2'b11;
`else
  localparam logic [1:0] OFF = 2'b00;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] mode = 3'd0;
  logic [1:0] pwm, l_in, r_in;
  logic settled;

  always #5 clk = ~clk;

  motor_ramp_drive #(.PWM_BITS(4), .DUTY_RUN(RUN), .DUTY_TURN(TURN), .RAMP_STEP(STEP), .REVERSE_DELAY(DLY)) dut (
    .clk(clk), .rst(rst), .mode_i(mode), .pwm_o(pwm), .l_in_o(l_in), .r_in_o(r_in), .settled_o(settled)
  );

  int checks = 0, errors = 0;
  // model: index 1 = left, 0 = right; phase 0 drive, 1 ramp-down, 2 dwell; dir +1 fwd, -1 back, 0 off
  int m_cnt = 0, m_duty[2] = '{0, 0}, m_ph[2] = '{0, 0}, m_dir[2] = '{0, 0}, m_dw[2] = '{0, 0};
  logic [1:0] m_pwm = 2'b00, m_in[2] = '{2'b00, 2'b00};
  logic m_set = 1'b1;

  function automatic int imin(int a, int b); return a < b ? a : b; endfunction
  function automatic int imax(int a, int b); return a > b ? a : b; endfunction

  function automatic int req_dir(int w, logic [2:0] md);
    case (md)
      3'd3: return 1;
      3'd4: return -1;
      3'd2: return w == 1 ? -1 : 1;
      3'd1: return w == 1 ? 1 : -1;
      default: return 0;
    endcase
  endfunction

  function automatic int req_tgt(logic [2:0] md);
    return (md == 3'd3 || md == 3'd4) ? RUN : (md == 3'd1 || md == 3'd2) ? TURN : 0;
  endfunction

  function automatic logic [1:0] enc(int ph, int dir);
    return (ph == 2 || dir == 0) ? OFF : dir > 0 ? 2'b10 : 2'b01;
  endfunction

  task automatic wheel_step(int w, int r, int t);
    int d;
    d = m_duty[w];
    case (m_ph[w])
      0: begin
        if (r == 0 || r == m_dir[w]) begin
          d = t > d ? d + imin(STEP, t - d) : d - imin(STEP, d - t);
          if (r == 0 && d == 0) m_dir[w] = 0;
        end else if (m_dir[w] == 0) begin
          m_dir[w] = r;
          d = imin(STEP, t);
        end else begin
          d = imax(0, d - STEP);
          m_ph[w] = d == 0 ? 2 : 1;
          m_dw[w] = 0;
        end
      end
      1: begin
        d = imax(0, d - STEP);
        if (d == 0) begin m_ph[w] = 2; m_dw[w] = 0; end
      end
      default: begin
        m_dw[w]++;
        if (m_dw[w] >= DLY) begin
          m_ph[w] = 0;
          m_dir[w] = r;
          d = imin(STEP, t);
          m_dw[w] = 0;
        end
      end
    endcase
    m_duty[w] = d;
  endtask

  task automatic model_edge();
    int t;
    bit s;
    if (rst) begin
      m_cnt = 0;
      m_pwm = 2'b00;
      m_set = 1'b1;
      for (int w = 0; w < 2; w++) begin
        m_duty[w] = 0; m_ph[w] = 0; m_dir[w] = 0; m_dw[w] = 0; m_in[w] = 2'b00;
      end
    end else begin
      t = req_tgt(mode);
      s = 1'b1;
      for (int w = 0; w < 2; w++) if (m_ph[w] != 0 || m_duty[w] != t) s = 1'b0;
      m_set = s;
      if (m_cnt == MAXC) for (int w = 0; w < 2; w++) wheel_step(w, req_dir(w, mode), t);
      m_cnt = (m_cnt + 1) % (MAXC + 1);
      for (int w = 0; w < 2; w++) begin
        m_pwm[w] = m_cnt < m_duty[w];
        m_in[w] = enc(m_ph[w], m_dir[w]);
      end
    end
  endtask

  task automatic check(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("pwm", pwm, m_pwm);
    check("l_in", l_in, m_in[1]);
    check("r_in", r_in, m_in[0]);
    check("settled", {1'b0, settled}, {1'b0, m_set});
  endtask

  typedef struct {
    logic       r;
    logic [2:0] md;
    int         n;
    logic [1:0] p, l, rr;
    logic       s;
  } vec_t;
  vec_t tbl[32];

  initial begin
    tbl = '{
      '{1'b1, 3'd0,  3, 2'b00, 2'b00, 2'b00, 1'b1},
      '{1'b0, 3'd0,  5, 2'b00, OFF,   OFF,   1'b1},
      '{1'b0, 3'd3,  1, 2'b00, OFF,   OFF,   1'b0},
      '{1'b0, 3'd3, 10, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd3,  4, 2'b00, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd3, 12, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd3,  8, 2'b00, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd3,  8, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd3,  1, 2'b11, 2'b10, 2'b10, 1'b1},
      '{1'b0, 3'd3, 11, 2'b00, 2'b10, 2'b10, 1'b1},
      '{1'b0, 3'd4,  5, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd4, 15, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd4, 16, 2'b00, OFF,   OFF,   1'b0},
      '{1'b0, 3'd4, 16, 2'b00, OFF,   OFF,   1'b0},
      '{1'b0, 3'd4, 16, 2'b11, 2'b01, 2'b01, 1'b0},
      '{1'b0, 3'd4, 32, 2'b11, 2'b01, 2'b01, 1'b0},
      '{1'b0, 3'd4,  1, 2'b11, 2'b01, 2'b01, 1'b1},
      '{1'b0, 3'd7, 15, 2'b11, 2'b01, 2'b01, 1'b0},
      '{1'b0, 3'd7, 32, 2'b00, OFF,   OFF,   1'b0},
      '{1'b0, 3'd7,  1, 2'b00, OFF,   OFF,   1'b1},
      '{1'b0, 3'd3, 15, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd3, 16, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b1, 3'd3,  1, 2'b00, 2'b00, 2'b00, 1'b1},
      '{1'b0, 3'd3, 16, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd3, 32, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd3,  1, 2'b11, 2'b10, 2'b10, 1'b1},
      '{1'b0, 3'd2, 15, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd2, 16, 2'b11, 2'b10, 2'b10, 1'b0},
      '{1'b0, 3'd2, 16, 2'b01, OFF,   2'b10, 1'b0},
      '{1'b0, 3'd2, 32, 2'b11, 2'b01, 2'b10, 1'b0},
      '{1'b0, 3'd2, 16, 2'b11, 2'b01, 2'b10, 1'b0},
      '{1'b0, 3'd2,  1, 2'b11, 2'b01, 2'b10, 1'b1}
    };
    for (int i = 0; i < 32; i++) begin
      rst = tbl[i].r;
      mode = tbl[i].md;
      repeat (tbl[i].n) tick();
      check($sformatf("tbl%0d_pwm", i), pwm, tbl[i].p);
      check($sformatf("tbl%0d_l_in", i), l_in, tbl[i].l);
      check($sformatf("tbl%0d_r_in", i), r_in, tbl[i].rr);
      check($sformatf("tbl%0d_settled", i), {1'b0, settled}, {1'b0, tbl[i].s});
    end
    for (int k = 0; k < 60; k++) begin
      int n;
      mode = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 70);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      repeat (n) tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
